// File: rtl/top_k_tracker_pkg.sv
// rtl/top_k_tracker_pkg.sv - shared types, limits and width helpers for the top-K rank tracker
package top_k_pkg;

    localparam int K_MAX = 16;

    typedef enum logic {
        CMP_UNSIGNED = 1'b0,
        CMP_SIGNED   = 1'b1
    } cmp_mode_e;

    function automatic int rank_w(input int k);
        return $clog2(k);
    endfunction

    function automatic int cnt_w(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/top_k_tracker_if.sv
// rtl/top_k_tracker_if.sv - sample/readout bundle between a stream source and the top-K tracker
//   master: drives din_valid, din, clear, rank_sel; receives dout, topk, count, full
//   slave : the tracker side of the same signals
interface top_k_tracker_if #(
    parameter int DATA_SIZE = 32,
    parameter int K         = 4
);
    import top_k_pkg::*;

    localparam int RW = rank_w(K);
    localparam int CW = cnt_w(K);

    logic                   din_valid;
    logic [DATA_SIZE-1:0]   din;
    logic                   clear;
    logic [RW-1:0]          rank_sel;
    logic [DATA_SIZE-1:0]   dout;
    logic [K*DATA_SIZE-1:0] topk;
    logic [CW-1:0]          count;
    logic                   full;

    modport master (
        output din_valid, din, clear, rank_sel,
        input  dout, topk, count, full
    );

    modport slave (
        input  din_valid, din, clear, rank_sel,
        output dout, topk, count, full
    );

endinterface

// File: rtl/top_k_tracker_cmp.sv
// rtl/top_k_tracker_cmp.sv - single-rank comparator: gt = a > b, eq = a == b
//   a, b : DATA_SIZE operands; SIGNED selects two's-complement ordering
//   gt, eq : combinational results
module top_k_cmp
    import top_k_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int SIGNED    = 0
) (
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    output logic                 gt,
    output logic                 eq
);

    localparam cmp_mode_e MODE = (SIGNED != 0) ? CMP_SIGNED : CMP_UNSIGNED;

    always_comb begin
        if (MODE == CMP_SIGNED) begin
            gt = $signed(a) > $signed(b);
        end else begin
            gt = a > b;
        end
        eq = (a == b);
    end

endmodule

// File: rtl/top_k_tracker.sv
// rtl/top_k_tracker.sv - keeps the K largest samples since reset/clear, sorted descending
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : top_k_tracker_if.slave (din_valid, din, clear, rank_sel -> dout, topk, count, full)
//   Optional macro TOPK_UNIQUE_EN: samples equal to an occupied rank are discarded.
module top_k_tracker
    import top_k_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int K         = 4,
    parameter int SIGNED    = 0
) (
    input  logic            clk,
    input  logic            resetn,
    top_k_tracker_if.slave  bus
);

    localparam int RW = rank_w(K);
    localparam int CW = cnt_w(K);

`ifdef TOPK_UNIQUE_EN
    localparam bit UNIQUE = 1'b1;
`else
    localparam bit UNIQUE = 1'b0;
`endif

    logic [DATA_SIZE-1:0] vals     [K];
    logic [DATA_SIZE-1:0] nxt_vals [K];
    logic [K-1:0]         occ;
    logic [K-1:0]         nxt_occ;
    logic [K-1:0]         gt;
    logic [K-1:0]         eq;
    logic [K-1:0]         cand;
    logic                 dup;

    for (genvar g = 0; g < K; g++) begin : g_cmp
        top_k_cmp #(
            .DATA_SIZE (DATA_SIZE),
            .SIGNED    (SIGNED)
        ) u_cmp (
            .a  (bus.din),
            .b  (vals[g]),
            .gt (gt[g]),
            .eq (eq[g])
        );
    end

    // Ranks are sorted and contiguous, so cand is a thermometer: clear below the
    // insert point p, set from p upward. Its first set bit is p; every set rank
    // above p takes its lower neighbour, which drops the old rank K-1.
    always_comb begin
        cand = ~occ | gt;
        dup  = UNIQUE && |(eq & occ);

        nxt_vals[0] = cand[0] ? bus.din : vals[0];
        nxt_occ[0]  = occ[0] | cand[0];
        for (int i = 1; i < K; i++) begin
            if (!cand[i]) begin
                nxt_vals[i] = vals[i];
                nxt_occ[i]  = occ[i];
            end else if (!cand[i-1]) begin
                nxt_vals[i] = bus.din;
                nxt_occ[i]  = 1'b1;
            end else begin
                nxt_vals[i] = vals[i-1];
                nxt_occ[i]  = occ[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vals <= '{default: '0};
            occ  <= '0;
        end else if (bus.clear) begin
            vals <= '{default: '0};
            occ  <= '0;
        end else if (bus.din_valid && !dup) begin
            vals <= nxt_vals;
            occ  <= nxt_occ;
        end
    end

    // Outputs are masked by occ so an empty rank always reads as zero.
    always_comb begin
        bus.topk  = '0;
        bus.dout  = '0;
        bus.count = '0;
        for (int i = 0; i < K; i++) begin
            bus.topk[i*DATA_SIZE +: DATA_SIZE] = occ[i] ? vals[i] : '0;
            if (bus.rank_sel == RW'(i) && occ[i]) begin
                bus.dout = vals[i];
            end
            bus.count = bus.count + CW'(occ[i]);
        end
        bus.full = (bus.count == CW'(K));
    end

endmodule

// File: tb/tb_top_k_tracker.sv
// tb/tb_top_k_tracker.sv - randomized and directed self-checking bench for top_k_tracker
module tb_top_k_tracker;
    import top_k_pkg::*;

    localparam int DW = 8;
    localparam int KK = 4;

    typedef logic [DW-1:0] q_t[$];

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    q_t   mu;
    q_t   ms;

    always #5 clk = ~clk;

    top_k_tracker_if #(.DATA_SIZE(DW), .K(KK)) bu ();
    top_k_tracker_if #(.DATA_SIZE(DW), .K(KK)) bs ();

    top_k_tracker #(.DATA_SIZE(DW), .K(KK), .SIGNED(0)) dut_u (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bu)
    );

    top_k_tracker #(.DATA_SIZE(DW), .K(KK), .SIGNED(1)) dut_s (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bs)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int key(input logic [DW-1:0] v, input bit sg);
        if (sg) return int'($signed(v));
        return int'(v);
    endfunction

    // Insert index = number of held values that rank at or above the sample.
    function automatic q_t model_push(input q_t q, input logic [DW-1:0] v, input bit sg);
        q_t r;
        int pos;
        r   = q;
        pos = 0;
`ifdef TOPK_UNIQUE_EN
        foreach (q[i]) if (q[i] == v) return r;
`endif
        foreach (q[i]) if (key(q[i], sg) >= key(v, sg)) pos++;
        if (pos >= KK) return r;
        r.insert(pos, v);
        if (r.size() > KK) void'(r.pop_back());
        return r;
    endfunction

    function automatic logic [KK*DW-1:0] exp_topk(input q_t q);
        logic [KK*DW-1:0] t;
        t = '0;
        foreach (q[i]) t[i*DW +: DW] = q[i];
        return t;
    endfunction

    function automatic logic [DW-1:0] exp_rank(input q_t q, input int r);
        if (r < q.size()) return q[r];
        return '0;
    endfunction

    task automatic check_all(input string ph);
        check({ph, "_topk_u"},  64'(bu.topk),  64'(exp_topk(mu)));
        check({ph, "_count_u"}, 64'(bu.count), 64'(mu.size()));
        check({ph, "_full_u"},  64'(bu.full),  64'(mu.size() == KK));
        check({ph, "_dout_u"},  64'(bu.dout),  64'(exp_rank(mu, int'(bu.rank_sel))));
        check({ph, "_topk_s"},  64'(bs.topk),  64'(exp_topk(ms)));
        check({ph, "_count_s"}, 64'(bs.count), 64'(ms.size()));
        check({ph, "_full_s"},  64'(bs.full),  64'(ms.size() == KK));
        check({ph, "_dout_s"},  64'(bs.dout),  64'(exp_rank(ms, int'(bs.rank_sel))));
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit c, input string ph);
        logic [1:0] rs;
        rs = 2'($urandom_range(0, KK - 1));
        bu.din_valid = v; bs.din_valid = v;
        bu.din = d;       bs.din = d;
        bu.clear = c;     bs.clear = c;
        bu.rank_sel = rs; bs.rank_sel = rs;
        @(posedge clk);
        if (c) begin
            mu.delete(); ms.delete();
        end else if (v) begin
            mu = model_push(mu, d, 1'b0);
            ms = model_push(ms, d, 1'b1);
        end
        #1;
        bu.din_valid = 1'b0; bs.din_valid = 1'b0;
        bu.clear = 1'b0;     bs.clear = 1'b0;
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic check_every_rank(input string ph);
        for (int r = 0; r < KK; r++) begin
            bu.rank_sel = 2'(r); bs.rank_sel = 2'(r);
            #1;
            check({ph, "_dout_u"}, 64'(bu.dout), 64'(exp_rank(mu, r)));
            check({ph, "_dout_s"}, 64'(bs.dout), 64'(exp_rank(ms, r)));
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        bu.din_valid = 1'b0; bs.din_valid = 1'b0;
        bu.din = '0;         bs.din = '0;
        bu.clear = 1'b0;     bs.clear = 1'b0;
        bu.rank_sel = '0;    bs.rank_sel = '0;

        // Reset state
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_all("reset");
        check("reset_topk_const", 64'(bu.topk), 64'h0);
        check_every_rank("reset");

        // Fill: 5,9,3,7 -> {9,7,5,3}
        step(1'b1, 8'd5, 1'b0, "fill");
        step(1'b1, 8'd9, 1'b0, "fill");
        step(1'b1, 8'd3, 1'b0, "fill");
        step(1'b1, 8'd7, 1'b0, "fill");
        check("fill_topk_const", 64'(bu.topk), 64'h03050709);
        check("fill_full_const", 64'(bu.full), 64'h1);
        bu.rank_sel = 2'd1; #1;
        check("fill_rank1_const", 64'(bu.dout), 64'd7);

        // Replacement, rejection, tie at the last rank
        step(1'b1, 8'd8, 1'b0, "repl");
        check("repl_topk_const", 64'(bu.topk), 64'h05070809);
        step(1'b1, 8'd2, 1'b0, "low");
        step(1'b1, 8'd5, 1'b0, "tie_last");
        check("tie_last_const", 64'(bu.topk), 64'h05070809);

        // Duplicate of the current maximum
        step(1'b1, 8'd9, 1'b0, "dup");
`ifdef TOPK_UNIQUE_EN
        check("dup_const", 64'(bu.topk), 64'h05070809);
`else
        check("dup_const", 64'(bu.topk), 64'h07080909);
`endif

        // Signed vs unsigned ordering
        step(1'b0, 8'd0, 1'b1, "clr");
        step(1'b1, 8'hFF, 1'b0, "sgn");
        step(1'b1, 8'h01, 1'b0, "sgn");
        step(1'b1, 8'h80, 1'b0, "sgn");
        check("sgn_u_const", 64'(bu.topk), 64'h000180FF);
        check("sgn_s_const", 64'(bs.topk), 64'h0080FF01);
        check("sgn_count_const", 64'(bs.count), 64'd3);

        // Clear beats a same-cycle sample
        step(1'b0, 8'd0, 1'b1, "clr");
        step(1'b1, 8'd4, 1'b0, "pre_clr");
        step(1'b1, 8'd6, 1'b0, "pre_clr");
        step(1'b1, 8'd50, 1'b1, "clr_win");
        check("clr_win_count_const", 64'(bu.count), 64'd0);
        step(1'b1, 8'd1, 1'b0, "post_clr");
        check("post_clr_const", 64'(bu.topk), 64'h00000001);

        // Asynchronous reset mid-stream
        step(1'b1, 8'd20, 1'b0, "pre_rst");
        bu.din_valid = 1'b1; bs.din_valid = 1'b1;
        bu.din = 8'd30;      bs.din = 8'd30;
        #2 resetn = 1'b0;
        #1;
        mu.delete(); ms.delete();
        check_all("async_rst");
        bu.din_valid = 1'b0; bs.din_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_all("after_rst");

        // Randomized stream with tie-heavy and sign-boundary values
        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 3))
                0: d = 8'($urandom_range(0, 7));
                1: d = 8'(8'hF8 + $urandom_range(0, 7));
                2: d = 8'(8'h7C + $urandom_range(0, 7));
                default: d = 8'($urandom);
            endcase
            step(($urandom % 4) != 0, d, ($urandom % 40) == 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
